// File: rtl/hostctrl_pkg.sv
// Shared types and constants for the host-controlled memory loader.
// Frame layout: 8 bytes LSB first, word index in bytes 0-3, data in bytes 4-7.
package hostctrl_pkg;

  typedef enum logic [1:0] {
    ST_RX   = 2'd0,
    ST_WR   = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int FRAME_LEN  = 8;
  localparam int BYTE_W     = 8;
  localparam int BYTE_CNT_W = 3;
  localparam int FRAME_W    = FRAME_LEN * BYTE_W;

  // Bit positions of the two fields inside the assembled frame.
  localparam int IDX_LO  = 0;
  localparam int IDX_HI  = 31;
  localparam int DATA_LO = 32;
  localparam int DATA_HI = 63;

  localparam logic [3:0] SEL_NONE    = 4'h0;
  localparam logic [3:0] SEL_ALL     = 4'hF;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  function automatic logic [31:0] word_to_adr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/hostctrl_byte_rx.sv
// Byte handshake with the host: arm/disarm on valid, one-cycle ack pulse,
// stuck-valid timeout, and LSB-first assembly of the 64-bit frame.
module hostctrl_byte_rx
  import hostctrl_pkg::*;
#(
  parameter int BYTE_HOLD_MAX = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [BYTE_W-1:0]     i_data,
  input  logic                  i_valid,
  input  logic                  i_enable,
  input  logic                  i_clear,
  output logic                  o_accept,
  output logic                  o_ack_data,
  output logic                  o_word_done,
  output logic                  o_hold_err,
  output logic [BYTE_CNT_W-1:0] o_byte_cnt,
  output logic [FRAME_W-1:0]    o_frame
);

  localparam int HOLD_W = $clog2(BYTE_HOLD_MAX + 1) + 1;

  logic                  r_armed;
  logic                  r_ack_data;
  logic                  r_word_done;
  logic                  r_hold_err;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [BYTE_CNT_W-1:0] r_cnt;
  logic [FRAME_W-1:0]    r_frame;
  logic                  w_accept;

  assign w_accept = i_valid && r_armed && i_enable;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed     <= 1'b1;
      r_ack_data  <= 1'b0;
      r_word_done <= 1'b0;
      r_hold_err  <= 1'b0;
      r_hold_cnt  <= '0;
      r_cnt       <= '0;
      r_frame     <= '0;
    end else begin
      r_ack_data  <= 1'b0;
      r_word_done <= 1'b0;
      r_hold_err  <= 1'b0;
      if (w_accept) begin
        r_armed    <= 1'b0;
        r_ack_data <= 1'b1;
        r_hold_cnt <= '0;
        r_frame    <= {i_data, r_frame[FRAME_W-1:BYTE_W]};
        r_cnt      <= r_cnt + BYTE_CNT_W'(1);
        if (r_cnt == BYTE_CNT_W'(FRAME_LEN - 1)) begin
          r_word_done <= 1'b1;
        end
      end else if (!r_armed) begin
        if (!i_valid) begin
          r_armed    <= 1'b1;
          r_hold_cnt <= '0;
        end else if (r_hold_cnt == HOLD_W'(BYTE_HOLD_MAX)) begin
          // Host never dropped valid: flag it and re-arm so loading can proceed.
          r_armed    <= 1'b1;
          r_hold_cnt <= '0;
          r_hold_err <= 1'b1;
        end else begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
      end
      if (i_clear) begin
        r_cnt <= '0;
      end
    end
  end

  assign o_accept    = w_accept;
  assign o_ack_data  = r_ack_data;
  assign o_word_done = r_word_done;
  assign o_hold_err  = r_hold_err;
  assign o_byte_cnt  = r_cnt;
  assign o_frame     = r_frame;

endmodule

// File: rtl/hostctrl_loader.sv
// Loads memory from a byte-serial host interface over a Wishbone master and
// holds the CPU in reset until the host signals that loading is complete.
module hostctrl_loader
  import hostctrl_pkg::*;
#(
  parameter logic [31:0] MEM_SIZE      = 32'h02000000,
  parameter int          BYTE_HOLD_MAX = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [7:0]  hostctrl_data_i,
  input  logic        hostctrl_valid_i,
  input  logic        hostctrl_next_i,
  input  logic        hostctrl_done_i,
  output logic        hostctrl_ack_data_o,
  output logic        hostctrl_ack_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        cpu_rst_o,
  output logic        load_err_o,
  output logic [15:0] words_o,
  output state_t      dbg_state_o
);

  localparam logic [31:0] MEM_WORDS = MEM_SIZE >> 2;

  // Handshake (all wishbone signals): a write starts with cyc/stb/we high and
  // stays unchanged until wbm_ack_i or wbm_err_i is sampled; cyc/stb drop on
  // that same clock edge, so they are low in the following cycle.

  state_t                r_state;
  logic                  r_ack;
  logic                  r_cpu_rst;
  logic                  r_load_err;
  logic                  r_wr_ok;
  logic [15:0]           r_words;
  logic [31:0]           r_adr;
  logic [31:0]           r_dat;
  logic [3:0]            r_sel;
  logic                  r_we;
  logic                  r_cyc;
  logic                  r_stb;
  logic [2:0]            r_cti;
  logic [1:0]            r_bte;

  logic                  w_accept;
  logic                  w_ack_data;
  logic                  w_word_done;
  logic                  w_hold_err;
  logic                  w_rx_en;
  logic                  w_clear;
  logic                  w_in_range;
  logic                  w_unused;
  logic [BYTE_CNT_W-1:0] w_byte_cnt;
  logic [FRAME_W-1:0]    w_frame;
  logic [31:0]           w_idx;
  logic [31:0]           w_data;

  assign w_unused   = hostctrl_next_i;
  assign w_idx      = w_frame[IDX_HI:IDX_LO];
  assign w_data     = w_frame[DATA_HI:DATA_LO];
  assign w_in_range = (w_idx < MEM_WORDS);

  // No byte is taken while a completed frame waits to be dispatched or while
  // the host is finishing, so the frame register stays stable through WR.
  assign w_rx_en = (r_state == ST_RX) && !hostctrl_done_i && !w_word_done;
  assign w_clear = (r_state == ST_RX) && hostctrl_done_i && !w_word_done &&
                   (w_byte_cnt != '0);

  hostctrl_byte_rx #(
    .BYTE_HOLD_MAX (BYTE_HOLD_MAX)
  ) u_byte_rx (
    .i_clk       (wb_clk_i),
    .i_rst_n     (wb_rst_n_i),
    .i_data      (hostctrl_data_i),
    .i_valid     (hostctrl_valid_i),
    .i_enable    (w_rx_en),
    .i_clear     (w_clear),
    .o_accept    (w_accept),
    .o_ack_data  (w_ack_data),
    .o_word_done (w_word_done),
    .o_hold_err  (w_hold_err),
    .o_byte_cnt  (w_byte_cnt),
    .o_frame     (w_frame)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state    <= ST_RX;
      r_ack      <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_load_err <= 1'b0;
      r_wr_ok    <= 1'b0;
      r_words    <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_sel      <= SEL_NONE;
      r_we       <= 1'b0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_cti      <= CTI_CLASSIC;
      r_bte      <= BTE_LINEAR;
    end else begin
      if (w_hold_err && (r_state != ST_DONE)) begin
        r_load_err <= 1'b1;
      end
      case (r_state)
        ST_RX: begin
          if (w_accept) begin
            r_ack <= 1'b0;
          end
          if (w_word_done) begin
            if (w_in_range) begin
              r_adr   <= word_to_adr(w_idx[29:0]);
              r_dat   <= w_data;
              r_sel   <= SEL_ALL;
              r_we    <= 1'b1;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_cti   <= CTI_EOB;
              r_bte   <= BTE_LINEAR;
              r_state <= ST_WR;
            end else begin
              r_load_err <= 1'b1;
              r_wr_ok    <= 1'b0;
              r_state    <= ST_ACK;
            end
          end else if (hostctrl_done_i) begin
            if (w_byte_cnt != '0) begin
              r_load_err <= 1'b1;
            end
            r_ack   <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_WR: begin
          if (wbm_ack_i || wbm_err_i) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= SEL_NONE;
            r_cti   <= CTI_CLASSIC;
            r_wr_ok <= !wbm_err_i;
            if (wbm_err_i) begin
              r_load_err <= 1'b1;
            end
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_ack <= 1'b1;
          if (r_wr_ok && (r_words != 16'hFFFF)) begin
            r_words <= r_words + 16'd1;
          end
          r_state <= ST_RX;
        end
        ST_DONE: begin
          r_cpu_rst <= 1'b0;
        end
        default: begin
          r_state <= ST_RX;
        end
      endcase
    end
  end

  assign hostctrl_ack_data_o = w_ack_data;
  assign hostctrl_ack_o      = r_ack;
  assign wbm_adr_o           = r_adr;
  assign wbm_dat_o           = r_dat;
  assign wbm_sel_o           = r_sel;
  assign wbm_we_o            = r_we;
  assign wbm_cyc_o           = r_cyc;
  assign wbm_stb_o           = r_stb;
  assign wbm_cti_o           = r_cti;
  assign wbm_bte_o           = r_bte;
  assign cpu_rst_o           = r_cpu_rst;
  assign load_err_o          = r_load_err;
  assign words_o             = r_words;
  assign dbg_state_o         = r_state;

endmodule

// File: tb/tb_hostctrl_loader.sv
// Self-checking bench for hostctrl_loader: host byte driver, Wishbone slave
// with an expected-write queue, and a word-level reference model.
`timescale 1ns/1ps
module tb_hostctrl_loader;
  import hostctrl_pkg::*;

  localparam logic [31:0] MEM_WORDS = 32'h00800000;

  // clock / reset
  logic wb_clk_i   = 1'b0;
  logic wb_rst_n_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  logic [7:0]  hostctrl_data_i  = '0;
  logic        hostctrl_valid_i = 1'b0;
  logic        hostctrl_next_i  = 1'b0;
  logic        hostctrl_done_i  = 1'b0;
  logic        hostctrl_ack_data_o, hostctrl_ack_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        cpu_rst_o, load_err_o;
  logic [15:0] words_o;
  state_t      dbg_state;

  hostctrl_loader dut (
    .wb_clk_i            (wb_clk_i),
    .wb_rst_n_i          (wb_rst_n_i),
    .hostctrl_data_i     (hostctrl_data_i),
    .hostctrl_valid_i    (hostctrl_valid_i),
    .hostctrl_next_i     (hostctrl_next_i),
    .hostctrl_done_i     (hostctrl_done_i),
    .hostctrl_ack_data_o (hostctrl_ack_data_o),
    .hostctrl_ack_o      (hostctrl_ack_o),
    .wbm_adr_o           (wbm_adr_o),
    .wbm_dat_o           (wbm_dat_o),
    .wbm_sel_o           (wbm_sel_o),
    .wbm_we_o            (wbm_we_o),
    .wbm_cyc_o           (wbm_cyc_o),
    .wbm_stb_o           (wbm_stb_o),
    .wbm_cti_o           (wbm_cti_o),
    .wbm_bte_o           (wbm_bte_o),
    .wbm_ack_i           (wbm_ack_i),
    .wbm_err_i           (wbm_err_i),
    .cpu_rst_o           (cpu_rst_o),
    .load_err_o          (load_err_o),
    .words_o             (words_o),
    .dbg_state_o         (dbg_state)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model (word level)
  logic [63:0] exp_q[$];
  logic [15:0] m_words = '0;
  logic        m_err   = 1'b0;

  // wishbone slave + scoreboard
  int          ack_delay = 0;
  bit          use_err   = 1'b0;
  int          stb_cnt   = 0;
  int          wb_cycles = 0;
  logic [31:0] last_adr  = '0;

  always @(negedge wb_clk_i) begin
    logic [63:0] e;
    if (!wb_rst_n_i) begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      stb_cnt   = 0;
    end else if (wbm_cyc_o && wbm_stb_o) begin
      if (!wbm_ack_i && !wbm_err_i) begin
        stb_cnt++;
        if (stb_cnt == 1) begin
          wb_cycles++;
          last_adr = wbm_adr_o;
          check("wb_sel", wbm_sel_o, 4'hF);
          check("wb_we", wbm_we_o, 1);
          check("wb_cti", wbm_cti_o, 3'b111);
          check("wb_bte", wbm_bte_o, 2'b00);
          if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("wb_adr", wbm_adr_o, e[63:32]);
            check("wb_dat", wbm_dat_o, e[31:0]);
          end
        end
        if (stb_cnt == ack_delay + 1) begin
          if (use_err) wbm_err_i = 1'b1;
          else         wbm_ack_i = 1'b1;
        end
      end
    end else begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      stb_cnt   = 0;
    end
  end

  // host-side and strobe monitors
  int   ack_pulses = 0;
  int   since_ack  = 0;
  int   last_lat   = -1;
  int   stb_run    = 0;
  int   last_run   = 0;
  logic prev_stb   = 1'b0;

  always @(negedge wb_clk_i) begin
    if (hostctrl_ack_data_o) begin
      ack_pulses++;
      since_ack = 0;
    end else begin
      since_ack++;
    end
    if (wbm_stb_o && !prev_stb) last_lat = since_ack;
    if (wbm_stb_o) stb_run++;
    else if (stb_run != 0) begin
      last_run = stb_run;
      stb_run  = 0;
    end
    prev_stb = wbm_stb_o;
  end

  // driver tasks
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_reset();
    #2;
    wb_rst_n_i       = 1'b0;
    hostctrl_valid_i = 1'b0;
    hostctrl_done_i  = 1'b0;
    ack_delay        = 0;
    use_err          = 1'b0;
    repeat (3) tick();
    wb_rst_n_i = 1'b1;
    exp_q.delete();
    m_words = '0;
    m_err   = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    int n = 0;
    tick();
    hostctrl_data_i  = b;
    hostctrl_valid_i = 1'b1;
    do begin
      tick();
      n++;
    end while (!hostctrl_ack_data_o && n < 100);
    if (!hostctrl_ack_data_o) check("byte_ack_timeout", 0, 1);
    for (int i = 1; i < hold; i++) tick();
    hostctrl_valid_i = 1'b0;
    hostctrl_data_i  = 8'($urandom);
  endtask

  task automatic wait_word_ack();
    int n = 0;
    while (!hostctrl_ack_o && n < 300) begin
      tick();
      n++;
    end
    if (!hostctrl_ack_o) check("word_ack_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [31:0] idx, input logic [31:0] data, input int hold);
    logic [63:0] frame;
    logic [31:0] adr;
    logic        in_range;
    int          wb_before;
    frame     = {data, idx};
    adr       = idx * 4;
    in_range  = (idx < MEM_WORDS);
    wb_before = wb_cycles;
    if (in_range) exp_q.push_back({adr, data});
    ack_pulses = 0;
    for (int b = 0; b < 8; b++) send_byte(frame[8*b +: 8], hold);
    wait_word_ack();
    if (!in_range || use_err) m_err = 1'b1;
    else if (m_words != 16'hFFFF) m_words = m_words + 16'd1;
    check("ack_pulses", ack_pulses, 8);
    check("hostctrl_ack", hostctrl_ack_o, 1);
    check("words", words_o, m_words);
    check("load_err", load_err_o, m_err);
    check("cpu_rst_hold", cpu_rst_o, 1);
    check("wb_count", wb_cycles - wb_before, in_range ? 1 : 0);
    if (in_range) check("wb_latency", last_lat, 1);
    check("sb_drained", exp_q.size(), 0);
  endtask

  task automatic finish_load(input logic exp_err, input logic [15:0] exp_words);
    tick();
    hostctrl_done_i = 1'b1;
    tick();
    check("state_done", (dbg_state == ST_DONE), 1);
    check("cpu_rst_first_cycle", cpu_rst_o, 1);
    tick();
    check("cpu_rst_released", cpu_rst_o, 0);
    check("done_load_err", load_err_o, exp_err);
    check("done_words", words_o, exp_words);
    check("done_ack_low", hostctrl_ack_o, 0);
    // valid must be ignored in DONE, including the stuck-valid timeout
    ack_pulses = 0;
    hostctrl_valid_i = 1'b1;
    repeat (25) tick();
    hostctrl_valid_i = 1'b0;
    tick();
    check("done_no_bytes", ack_pulses, 0);
    check("done_err_stable", load_err_o, exp_err);
  endtask

  initial begin
    logic [31:0] ridx;
    int n;

    // A: reset values, nominal words, stretched ack, bus error
    do_reset();
    check("rst_cpu_rst", cpu_rst_o, 1);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_we", wbm_we_o, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat", wbm_dat_o, 0);
    check("rst_sel", wbm_sel_o, 0);
    check("rst_cti", wbm_cti_o, 0);
    check("rst_bte", wbm_bte_o, 0);
    check("rst_words", words_o, 0);
    check("rst_load_err", load_err_o, 0);
    check("rst_ack", hostctrl_ack_o, 0);
    check("rst_ack_data", hostctrl_ack_data_o, 0);

    send_word(32'h40, 32'hDEADBEEF, 1);
    check("deadbeef_adr", last_adr, 32'h100);
    send_word(32'($urandom_range(0, 32'h7FFFFF)), $urandom, 3);
    for (int i = 0; i < 12; i++) begin
      ack_delay = $urandom_range(0, 3);
      send_word(32'($urandom_range(0, 32'h7FFFFF)), $urandom, $urandom_range(1, 4));
    end
    ack_delay = 5;
    send_word(32'h7FFFFF, $urandom, 2);
    check("stb_len_delay5", last_run, 6);
    ack_delay = 2;
    use_err   = 1'b1;
    send_word(32'($urandom_range(0, 32'h7FFFFF)), $urandom, 1);
    use_err   = 1'b0;

    // B: out-of-range indices skip the bus
    do_reset();
    send_word(32'h00800000, 32'h12345678, 1);
    send_word(32'($urandom_range(32'h00800000, 32'hFFFFFFFF)), $urandom, 2);
    send_word(32'($urandom_range(0, 32'h7FFFFF)), $urandom, 1);

    // C: done after a partial word
    do_reset();
    for (int b = 0; b < 3; b++) send_byte(8'($urandom), 1);
    finish_load(1'b1, 16'd0);
    check("partial_no_wb", exp_q.size(), 0);

    // D: done after two complete words
    do_reset();
    send_word(32'($urandom_range(0, 32'h7FFFFF)), $urandom, 1);
    send_word(32'($urandom_range(0, 32'h7FFFFF)), $urandom, 2);
    finish_load(1'b0, 16'd2);

    // E: reset while the write is outstanding
    do_reset();
    ack_delay = 1000;
    ridx = 32'($urandom_range(0, 32'h7FFFFF));
    exp_q.push_back({ridx * 4, 32'hA5A5_0F0F});
    for (int b = 0; b < 8; b++) send_byte(8'({32'hA5A5_0F0F, ridx} >> (8 * b)), 1);
    n = 0;
    while (!wbm_stb_o && n < 50) begin
      tick();
      n++;
    end
    check("midwr_stb_seen", wbm_stb_o, 1);
    #2;
    wb_rst_n_i = 1'b0;
    #1;
    check("async_cyc_drop", wbm_cyc_o, 0);
    check("async_stb_drop", wbm_stb_o, 0);
    check("async_words", words_o, 0);
    do_reset();
    send_word(32'($urandom_range(0, 32'h7FFFFF)), $urandom, 1);

    // F: valid stuck high past the hold limit
    do_reset();
    ack_pulses = 0;
    send_byte(8'($urandom), 30);
    tick();
    check("hold_timeout_err", load_err_o, 1);
    check("hold_rearm", (ack_pulses > 1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/hostctrl_loader.md
HOSTCTRL_LOADER -- requirements
Module: hostctrl_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 32'h02000000, memory size in bytes; word indices at or above MEM_SIZE/4 are out of range.
REQ-002 SHALL have parameter BYTE_HOLD_MAX, default 16, timeout in cycles for valid staying high after a byte ack.
REQ-003 SHALL have port wb_clk_i, input, 1 bit, single clock for all logic.
REQ-004 SHALL have port wb_rst_n_i, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port hostctrl_data_i, input, 8 bits, byte from host.
REQ-006 SHALL have port hostctrl_valid_i, input, 1 bit, byte on hostctrl_data_i is valid.
REQ-007 SHALL have port hostctrl_next_i, input, 1 bit, host advance strobe (informational; re-arm uses valid low).
REQ-008 SHALL have port hostctrl_done_i, input, 1 bit, host has finished loading.
REQ-009 SHALL have port hostctrl_ack_data_o, output, 1 bit, per-byte acknowledge.
REQ-010 SHALL have port hostctrl_ack_o, output, 1 bit, per-word acknowledge.
REQ-011 SHALL have Wishbone master outputs: wbm_adr_o 32, wbm_dat_o 32, wbm_sel_o 4, wbm_we_o 1, wbm_cyc_o 1, wbm_stb_o 1, wbm_cti_o 3, wbm_bte_o 2.
REQ-012 SHALL have Wishbone master inputs wbm_ack_i 1 and wbm_err_i 1.
REQ-013 SHALL have port cpu_rst_o, output, 1 bit; holds the CPU in reset until loading completes.
REQ-014 SHALL have port load_err_o, output, 1 bit, sticky error flag.
REQ-015 SHALL have port words_o, output, 16 bits, count of words written.

Function
REQ-016 SHALL frame each word as 8 bytes, LSB first: 4 address bytes (word index) then 4 data bytes.
REQ-017 SHALL accept a byte when hostctrl_valid_i=1 and the block is armed; on acceptance it SHALL pulse hostctrl_ack_data_o high for exactly 1 cycle and disarm.
REQ-018 SHALL re-arm only after hostctrl_valid_i is sampled low; no byte is captured twice while valid stays high.
REQ-019 SHALL, when disarmed with valid high for more than BYTE_HOLD_MAX cycles, set load_err_o and force re-arm.
REQ-020 SHALL use the states RX (bytes 0-7, 3-bit counter), WR (Wishbone write), ACK, DONE; reset enters RX.
REQ-021 SHALL, after byte 7, enter WR and drive wbm_adr_o={idx[29:0],2'b00}, wbm_dat_o=data, wbm_sel_o=4'hF, wbm_we_o=1, wbm_cyc_o=wbm_stb_o=1, wbm_cti_o=3'b111, wbm_bte_o=2'b00.
REQ-022 SHALL hold the WR outputs until wbm_ack_i or wbm_err_i, then drop cyc/stb the next cycle; wbm_err_i sets load_err_o.
REQ-023 SHALL, for an out-of-range idx, skip WR, set load_err_o, and go directly to ACK.
REQ-024 SHALL enter ACK, raise hostctrl_ack_o, increment words_o (saturating at 16'hFFFF, successful writes only) and return to RX; hostctrl_ack_o stays high until the next byte is accepted or DONE is entered.
REQ-025 SHALL, when hostctrl_done_i=1 in RX with byte count 0, enter DONE; if the byte count is nonzero, it SHALL discard the partial word, set load_err_o and enter DONE.
REQ-026 SHALL ignore hostctrl_done_i while in WR; it is acted on after return to RX.
REQ-027 SHALL ignore valid in DONE and deassert cpu_rst_o one cycle after DONE entry; DONE is left only by reset.
REQ-028 SHALL give a byte-accept-to-Wishbone-strobe latency of 1 cycle after byte 7 acceptance.

Reset
REQ-029 SHALL, while wb_rst_n_i=0, set: state RX, byte count 0, armed=1, cpu_rst_o=1, hostctrl_ack_data_o=0, hostctrl_ack_o=0, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o/dat_o=0, wbm_sel_o=0, wbm_cti_o=0, wbm_bte_o=0, load_err_o=0, words_o=0.
REQ-030 SHALL, on reset mid-transfer, drop cyc/stb immediately and discard the partial word.

Structure
REQ-031 SHALL place the state enum, frame length (8), byte-lane constants and Wishbone CTI/BTE constants in package hostctrl_pkg.
REQ-032 SHALL implement the byte handshake (arm/disarm, ack pulse, hold timeout, 64-bit shift assembly) in sub-module hostctrl_byte_rx.

Verification
REQ-033 SHALL cover: one word, idx=0x40, data=0xDEADBEEF, sent LSB first -> single write adr=0x100, dat=0xDEADBEEF, sel=F; hostctrl_ack_o high; words_o=1.
REQ-034 SHALL cover: valid held 3 cycles per byte -> exactly 8 hostctrl_ack_data_o pulses per word, no duplicated bytes.
REQ-035 SHALL cover: idx=0x00800000 with MEM_SIZE default -> no Wishbone cycle, load_err_o=1, hostctrl_ack_o still raised.
REQ-036 SHALL cover: wbm_ack_i delayed 5 cycles -> stb held for 6 cycles; then wbm_err_i -> load_err_o=1, words_o unchanged.
REQ-037 SHALL cover: done after 3 bytes -> DONE, load_err_o=1, cpu_rst_o=0; done after 2 full words -> cpu_rst_o=0, load_err_o=0.
REQ-038 SHALL cover: wb_rst_n_i asserted during WR -> cyc/stb=0 asynchronously; after release, a fresh word is written correctly.
